// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, default data-memory depth and the
// data-memory FSM state encoding, plus the address-acceptance rule.
package cpu_pkg;

    localparam int WORD_W              = 32;
    localparam int DEFAULT_DEPTH_WORDS = 256;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } mem_state_t;

    // A byte address is accepted only when word aligned and every bit above
    // the word index is zero, so out-of-range addresses never alias.
    function automatic logic addr_valid(input logic [WORD_W-1:0] addr, input int aw);
        logic [WORD_W-1:0] upper;
        upper = addr >> (aw + 2);
        return (addr[1:0] == 2'b00) && (upper == '0);
    endfunction

endpackage

// File: rtl/data_memory_if.sv
// CPU memory-stage bus to the data memory: byte address, store data, request
// strobes, registered load data and status flags.
interface data_memory_if;
    import cpu_pkg::*;

    logic [WORD_W-1:0] data_addr;
    logic [WORD_W-1:0] mem_write_data;
    logic              mem_read;
    logic              mem_write;
    logic [WORD_W-1:0] mem_read_data;
    logic              busy;
    logic              addr_error;

    modport master (
        output data_addr,
        output mem_write_data,
        output mem_read,
        output mem_write,
        input  mem_read_data,
        input  busy,
        input  addr_error
    );

    modport slave (
        input  data_addr,
        input  mem_write_data,
        input  mem_read,
        input  mem_write,
        output mem_read_data,
        output busy,
        output addr_error
    );

endinterface

// File: rtl/mem_array_1r1w.sv
// Word array with one synchronous write port and one registered read port.
// No reset, so it maps onto block RAM; a same-address read returns old data.
module mem_array_1r1w #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int W     = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port holds its value whenever re is low.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/data_memory.sv
// CPU data memory: zero-fills the array after reset, then serves word
// loads/stores with address checking and a one-cycle error pulse.
module data_memory
    import cpu_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    data_memory_if.slave  bus
);

    mem_state_t         state_reg;
    logic [AW-1:0]      clr_idx_reg;
    logic               busy_reg;
    logic               addr_error_reg;
    logic               rd_valid_reg;

    logic               ready;
    logic               access_ok;
    logic [AW-1:0]      word_idx;
    logic               arr_we;
    logic [AW-1:0]      arr_waddr;
    logic [WORD_W-1:0]  arr_wdata;
    logic               arr_re;
    logic [WORD_W-1:0]  arr_rdata;

    assign ready     = (state_reg == READY);
    assign access_ok = addr_valid(bus.data_addr, AW);
    assign word_idx  = bus.data_addr[AW+1:2];

    // The single write port is shared: clear counter in CLEAR, CPU store in READY.
    assign arr_we    = !ready || (bus.mem_write && access_ok);
    assign arr_waddr = ready ? word_idx : clr_idx_reg;
    assign arr_wdata = ready ? bus.mem_write_data : '0;
    assign arr_re    = ready && bus.mem_read && access_ok;

    mem_array_1r1w #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW),
        .W     (WORD_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .re    (arr_re),
        .raddr (word_idx),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= CLEAR;
            clr_idx_reg    <= '0;
            busy_reg       <= 1'b1;
            addr_error_reg <= 1'b0;
            rd_valid_reg   <= 1'b0;
        end else begin
            case (state_reg)
                CLEAR: begin
                    addr_error_reg <= 1'b0;
                    rd_valid_reg   <= 1'b0;
                    if (clr_idx_reg == AW'(DEPTH_WORDS - 1)) begin
                        state_reg   <= READY;
                        busy_reg    <= 1'b0;
                        clr_idx_reg <= '0;
                    end else begin
                        clr_idx_reg <= clr_idx_reg + 1'b1;
                    end
                end
                READY: begin
                    busy_reg       <= 1'b0;
                    addr_error_reg <= (bus.mem_read || bus.mem_write) && !access_ok;
                    // A rejected load forces the output to zero until the next good load.
                    if (bus.mem_read) begin
                        rd_valid_reg <= access_ok;
                    end
                end
                default: begin
                    state_reg <= CLEAR;
                    busy_reg  <= 1'b1;
                end
            endcase
        end
    end

    // The array register cannot be reset, so the output is masked until a valid load.
    assign bus.mem_read_data = rd_valid_reg ? arr_rdata : '0;
    assign bus.busy          = busy_reg;
    assign bus.addr_error    = addr_error_reg;

endmodule
